int_to_fp: RTL and testbench

- Multi-cycle converter from a signed two's-complement fixed-point sample to an IEEE-754 single-precision float.
- It is the producing end of the float datapath. It feeds fp arithmetic units (adders, multipliers) with values originating from integer sources such as oscillators, counters, MIDI velocity and sample ROMs.
- Uses a start/done handshake and rounds to nearest, ties to even.

---
 rtl/fp_pkg.sv | 15 +
 rtl/lead_one32.sv | 20 ++
 rtl/int_to_fp.sv | 99 +++++++++
 tb/tb_int_to_fp.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared float-datapath constants and the converter state encoding.
package fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  typedef enum logic [1:0] {
    IDLE,
    ABS,
    NORM,
    ROUND
  } state_t;

endpackage

// File: rtl/lead_one32.sv
// Combinational leading-one detector: position of the most significant set bit.
module lead_one32 (
  input  logic [31:0] data_in,
  output logic [4:0]  pos,
  output logic        valid
);

  // Ascending scan so the highest set bit is the last one to write pos.
  always_comb begin
    pos   = '0;
    valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (data_in[i]) begin
        pos   = i[4:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_to_fp.sv
// Multi-cycle signed fixed-point to IEEE-754 single converter, round to nearest even.
module int_to_fp
  import fp_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  state_t      state;
  logic [31:0] data_q;
  logic        sign_q;
  logic        zero_q;
  logic [32:0] mag_q;
  logic [31:0] norm_q;
  logic [8:0]  exp_pre_q;

  logic [4:0]  lz_pos;
  logic        lz_valid;

  logic [23:0] mant24;
  logic        round_up;
  logic [24:0] sum;
  logic [8:0]  exp_fin;
  logic [FP_MANT_W-1:0] frac;
  logic        unused_bits;

  lead_one32 u_lead_one (
    .data_in (mag_q[31:0]),
    .pos     (lz_pos),
    .valid   (lz_valid)
  );

  // Rounding of the normalised magnitude; a carry out means the mantissa wrapped to 1.0.
  always_comb begin
    mant24   = norm_q[31:8];
    round_up = norm_q[7] & ((|norm_q[6:0]) | norm_q[8]);
    sum      = {1'b0, mant24} + {24'd0, round_up};
    exp_fin  = exp_pre_q;
    frac     = sum[FP_MANT_W-1:0];
    if (sum[24]) begin
      exp_fin = exp_pre_q + 9'd1;
      frac    = '0;
    end
  end

  assign unused_bits = ^{mag_q[32], lz_valid, sum[23], exp_fin[8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data_q    <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      mag_q     <= '0;
      norm_q    <= '0;
      exp_pre_q <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_q <= dataa;
            done   <= 1'b0;
            busy   <= 1'b1;
            state  <= ABS;
          end
        end
        ABS: begin
          sign_q <= data_q[31];
          zero_q <= (data_q == 32'd0);
          mag_q  <= data_q[31] ? (33'd0 - {data_q[31], data_q}) : {1'b0, data_q};
          state  <= NORM;
        end
        NORM: begin
          norm_q    <= mag_q[31:0] << (5'd31 - lz_pos);
          exp_pre_q <= 9'(FP_BIAS) + 9'(lz_pos) - 9'(FRAC_BITS);
          state     <= ROUND;
        end
        ROUND: begin
          result <= zero_q ? 32'd0 : {sign_q, exp_fin[FP_EXP_W-1:0], frac};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp with FRAC_BITS=0 and FRAC_BITS=16 instances side by side.
module tb_int_to_fp;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result0, result16;
  logic        done0, done16, busy0, busy16;

  int checks;
  int failures;

  int_to_fp #(.FRAC_BITS(0)) dut0 (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataa  (dataa),
    .result (result0),
    .done   (done0),
    .busy   (busy0)
  );

  int_to_fp #(.FRAC_BITS(16)) dut16 (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataa  (dataa),
    .result (result16),
    .done   (done16),
    .busy   (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact magnitude, scale by 2^-23 into [1,2), then round to nearest even.
  function automatic logic [31:0] model(input logic [31:0] x, input int frac_bits);
    longint v, m, q, rem, half;
    int p, sh, e;
    logic s;
    if (x == 32'd0) return 32'd0;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    e = 127 + p - frac_bits;
    return {s, e[7:0], q[22:0]};
  endfunction

  // Drives one start pulse and waits (bounded) for done; lat counts negedges after the drive.
  task automatic run_conv(input logic [31:0] x, output logic [31:0] r0,
                          output logic [31:0] r16, output int lat);
    @(negedge clk);
    start = 1'b1;
    dataa = x;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r0  = result0;
    r16 = result16;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (result0 !== 32'd0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got result=%h done=%b busy=%b expected 0/0/0", result0, done0, busy0);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] vals [3];
    logic [31:0] exps [3];
    logic [31:0] r0, r16;
    int lat;
    vals = '{32'd1, 32'hFFFFFFFF, 32'd0};
    exps = '{32'h3F800000, 32'hBF800000, 32'h00000000};
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], r0, r16, lat);
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("[TB] FAIL basic_latency: in=%h got %0d edges expected 4", vals[i], lat);
      end
      checks++;
      if (r0 !== exps[i]) begin
        failures++;
        $display("[TB] FAIL basic_result: in=%h got %h expected %h", vals[i], r0, exps[i]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] r0, r16;
    int lat;
    run_conv(32'h80000000, r0, r16, lat);
    checks++;
    if (r0 !== 32'hCF000000) begin
      failures++;
      $display("[TB] FAIL min_int: got %h expected CF000000", r0);
    end
    run_conv(32'h7FFFFFFF, r0, r16, lat);
    checks++;
    if (r0 !== 32'h4F000000) begin
      failures++;
      $display("[TB] FAIL max_int_carry: got %h expected 4F000000", r0);
    end
  endtask

  task automatic test_ties();
    logic [31:0] vals [3];
    logic [31:0] exps [3];
    logic [31:0] r0, r16;
    int lat;
    vals = '{32'd16777217, 32'd16777219, 32'd16777221};
    exps = '{32'h4B800000, 32'h4B800002, 32'h4B800002};
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], r0, r16, lat);
      checks++;
      if (r0 !== exps[i]) begin
        failures++;
        $display("[TB] FAIL tie_even: in=%0d got %h expected %h", vals[i], r0, exps[i]);
      end
    end
  endtask

  task automatic test_frac16();
    logic [31:0] vals [3];
    logic [31:0] exps [3];
    logic [31:0] r0, r16;
    int lat;
    vals = '{32'h00018000, 32'hFFFF0000, 32'h00000001};
    exps = '{32'h3FC00000, 32'hBF800000, 32'h37800000};
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], r0, r16, lat);
      checks++;
      if (r16 !== exps[i]) begin
        failures++;
        $display("[TB] FAIL frac16: in=%h got %h expected %h", vals[i], r16, exps[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, r0, r16, e0, e16;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      if (i % 2 == 1) x = x >> $urandom_range(0, 31);
      if (i % 3 == 0) x = -x;
      e0  = model(x, 0);
      e16 = model(x, 16);
      run_conv(x, r0, r16, lat);
      checks++;
      if (r0 !== e0 || lat !== 4) begin
        failures++;
        $display("[TB] FAIL random_f0: in=%h got %h lat=%0d expected %h lat=4", x, r0, lat, e0);
      end
      checks++;
      if (r16 !== e16 || done16 !== 1'b1) begin
        failures++;
        $display("[TB] FAIL random_f16: in=%h got %h done=%b expected %h done=1", x, r16, done16, e16);
      end
    end
  endtask

  task automatic test_start_during_busy();
    logic [31:0] a, b, ea;
    int lat;
    a  = 32'd123456789;
    b  = 32'hDEADBEEF;
    ea = model(a, 0);
    @(negedge clk);
    start = 1'b1;
    dataa = a;
    @(negedge clk);
    start = 1'b0;
    dataa = '0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_in_flight: got busy=%b expected 1", busy0);
    end
    start = 1'b1;
    dataa = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 3;
    while (!done0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (result0 !== ea || lat !== 4) begin
      failures++;
      $display("[TB] FAIL start_ignored: got %h lat=%0d expected %h lat=4", result0, lat, ea);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || result0 !== ea) begin
      failures++;
      $display("[TB] FAIL no_restart: got done=%b busy=%b result=%h expected 1/0/%h", done0, busy0, result0, ea);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0, r16, x;
    int lat;
    x = 32'hFFFFFF85;
    checks++;
    if (done0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_precondition: got done=%b expected 1", done0);
    end
    run_conv(x, r0, r16, lat);
    checks++;
    if (lat !== 4 || r0 !== model(x, 0)) begin
      failures++;
      $display("[TB] FAIL back_to_back: got %h lat=%0d expected %h lat=4", r0, lat, model(x, 0));
    end
  endtask

  task automatic test_reset_during_round();
    logic [31:0] r0, r16, x;
    int lat;
    x = 32'd1000;
    @(negedge clk);
    start = 1'b1;
    dataa = 32'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (done0 !== 1'b0 || result0 !== 32'd0 || busy0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_in_round: got done=%b result=%h busy=%b expected 0/0/0", done0, result0, busy0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || result0 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL aborted_silent: got done=%b result=%h expected 0/0", done0, result0);
    end
    run_conv(x, r0, r16, lat);
    checks++;
    if (lat !== 4 || r0 !== 32'h447A0000) begin
      failures++;
      $display("[TB] FAIL after_reset: got %h lat=%0d expected 447A0000 lat=4", r0, lat);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dataa    = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_ties();
    test_frac16();
    test_random();
    test_start_during_busy();
    test_back_to_back();
    test_reset_during_round();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
